// File: rtl/program_loader_if.sv
// Byte-stream ingress and instruction-memory write port of the boot loader.
// Also carries the CPU hold/status signals.
interface program_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic [7:0] imem_wdata;
  logic       cpu_hold;
  logic       load_done;
  logic       load_error;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_error
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_error
  );
endinterface

// File: rtl/program_loader.sv
// Framed boot loader: writes each data byte to imem one cycle after acceptance; cpu_hold drops
// two cycles after a good checksum byte. in_ready is a pure state decode (low in VERIFY/ERROR).
module program_loader #(
  parameter logic [7:0] LOAD_BASE = 8'h00
) (
  input  logic            clk,
  input  logic            reset,
  program_loader_if.slave ldr
);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CHECK, S_VERIFY, S_DONE, S_ERROR
  } state_t;

  state_t     state_q;
  logic [7:0] remaining_q;
  logic [7:0] sum_q;
  logic [7:0] wr_ptr_q;
  logic       imem_we_q;
  logic [7:0] imem_addr_q;
  logic [7:0] imem_wdata_q;
  logic       cpu_hold_q;
  logic       load_done_q;
  logic       load_error_q;

  logic       in_ready;
  logic       accept;
  logic [7:0] sum_d;
  logic [7:0] wr_ptr_d;
  logic [7:0] remaining_d;

  assign in_ready    = (state_q != S_VERIFY) && (state_q != S_ERROR);
  assign accept      = ldr.in_valid && in_ready;
  assign sum_d       = sum_q + ldr.in_data;
  assign wr_ptr_d    = wr_ptr_q + 8'd1;
  assign remaining_d = remaining_q - 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      remaining_q  <= 8'h00;
      sum_q        <= 8'h00;
      wr_ptr_q     <= 8'h00;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= 8'h00;
      imem_wdata_q <= 8'h00;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept && ldr.in_data == SYNC_BYTE) state_q <= S_LEN;
        end
        S_LEN: begin
          if (accept) begin
            remaining_q <= ldr.in_data;
            sum_q       <= 8'h00;
            wr_ptr_q    <= LOAD_BASE;
            state_q     <= (ldr.in_data != 8'h00) ? S_DATA : S_CHECK;
          end
        end
        S_DATA: begin
          if (accept) begin
            imem_we_q    <= 1'b1;
            imem_addr_q  <= wr_ptr_q;
            imem_wdata_q <= ldr.in_data;
            wr_ptr_q     <= wr_ptr_d;
            sum_q        <= sum_d;
            remaining_q  <= remaining_d;
            if (remaining_d == 8'h00) state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (accept) begin
            sum_q   <= sum_d;
            state_q <= S_VERIFY;
          end
        end
        S_VERIFY: begin
          if (sum_q == 8'h00) begin
            state_q     <= S_DONE;
            load_done_q <= 1'b1;
            cpu_hold_q  <= 1'b0;
          end else begin
            state_q      <= S_ERROR;
            load_error_q <= 1'b1;
          end
        end
        S_DONE: begin
          // A sync byte here restarts loading and re-asserts the core hold immediately.
          if (accept && ldr.in_data == SYNC_BYTE) begin
            state_q     <= S_LEN;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
          end
        end
        S_ERROR: begin
          state_q <= S_ERROR;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ldr.in_ready   = in_ready;
  assign ldr.imem_we    = imem_we_q;
  assign ldr.imem_addr  = imem_addr_q;
  assign ldr.imem_wdata = imem_wdata_q;
  assign ldr.cpu_hold   = cpu_hold_q;
  assign ldr.load_done  = load_done_q;
  assign ldr.load_error = load_error_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: one instance at LOAD_BASE 00, one at FE for address wrap.
module tb_program_loader;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  program_loader_if bus_a ();
  program_loader_if bus_b ();

  program_loader #(.LOAD_BASE(8'h00)) u_a (.clk(clk), .reset(reset), .ldr(bus_a));
  program_loader #(.LOAD_BASE(8'hFE)) u_b (.clk(clk), .reset(reset), .ldr(bus_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xa(input logic [7:0] b);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = b;
    tick();
    bus_a.in_valid = 1'b0;
  endtask

  task automatic xa_gap(input logic [7:0] b);
    xa(b);
    tick();
  endtask

  task automatic xb(input logic [7:0] b);
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = b;
    tick();
    bus_b.in_valid = 1'b0;
  endtask

  task automatic chk_wr_a(input string tag, input logic [7:0] addr, input logic [7:0] data);
    chk({tag, "_we"}, bus_a.imem_we, 1);
    chk({tag, "_addr"}, bus_a.imem_addr, addr);
    chk({tag, "_wdata"}, bus_a.imem_wdata, data);
  endtask

  task automatic chk_wr_b(input string tag, input logic [7:0] addr, input logic [7:0] data);
    chk({tag, "_we"}, bus_b.imem_we, 1);
    chk({tag, "_addr"}, bus_b.imem_addr, addr);
    chk({tag, "_wdata"}, bus_b.imem_wdata, data);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_rdy"}, bus_a.in_ready, 1);
    chk({tag, "_hold"}, bus_a.cpu_hold, 1);
    chk({tag, "_we"}, bus_a.imem_we, 0);
    chk({tag, "_addr"}, bus_a.imem_addr, 0);
    chk({tag, "_wdata"}, bus_a.imem_wdata, 0);
    chk({tag, "_done"}, bus_a.load_done, 0);
    chk({tag, "_err"}, bus_a.load_error, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = 8'h00;
    bus_b.in_valid = 1'b0;
    bus_b.in_data  = 8'h00;
    tick();
    tick();
    chk_reset_a("rst");
    chk("rst_b_hold", bus_b.cpu_hold, 1);
    reset = 1'b0;

    // Good frame, streamed continuously
    xa(8'hA5);
    chk("g_sync_we", bus_a.imem_we, 0);
    xa(8'h03);
    chk("g_len_we", bus_a.imem_we, 0);
    xa(8'h11); chk_wr_a("g_w0", 8'h00, 8'h11);
    xa(8'h22); chk_wr_a("g_w1", 8'h01, 8'h22);
    xa(8'h33); chk_wr_a("g_w2", 8'h02, 8'h33);
    xa(8'h9A);
    chk("g_verify_we", bus_a.imem_we, 0);
    chk("g_verify_rdy", bus_a.in_ready, 0);
    chk("g_verify_hold", bus_a.cpu_hold, 1);
    chk("g_verify_done", bus_a.load_done, 0);
    tick();
    chk("g_hold", bus_a.cpu_hold, 0);
    chk("g_done", bus_a.load_done, 1);
    chk("g_err", bus_a.load_error, 0);
    chk("g_rdy", bus_a.in_ready, 1);

    // Bad checksum, entered as a reload from DONE
    xa(8'hA5);
    chk("b_reload_hold", bus_a.cpu_hold, 1);
    chk("b_reload_done", bus_a.load_done, 0);
    xa(8'h02);
    xa(8'h10); chk_wr_a("b_w0", 8'h00, 8'h10);
    xa(8'h20); chk_wr_a("b_w1", 8'h01, 8'h20);
    xa(8'h00);
    chk("b_verify_we", bus_a.imem_we, 0);
    tick();
    chk("b_err", bus_a.load_error, 1);
    chk("b_rdy", bus_a.in_ready, 0);
    chk("b_hold", bus_a.cpu_hold, 1);
    chk("b_done", bus_a.load_done, 0);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b_ignore_we", bus_a.imem_we, 0);
      chk("b_ignore_rdy", bus_a.in_ready, 0);
      chk("b_ignore_err", bus_a.load_error, 1);
    end
    bus_a.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_a("b_rst");

    // Garbage then frame, in_valid toggling
    xa_gap(8'h00); chk("gg_00_we", bus_a.imem_we, 0);
    xa_gap(8'hFF); chk("gg_ff_we", bus_a.imem_we, 0);
    xa_gap(8'h5A); chk("gg_5a_we", bus_a.imem_we, 0);
    chk("gg_hold", bus_a.cpu_hold, 1);
    xa_gap(8'hA5);
    xa_gap(8'h01);
    chk("gg_pre_we", bus_a.imem_we, 0);
    xa(8'h7E); chk_wr_a("gg_w0", 8'h00, 8'h7E);
    tick(); chk("gg_one_shot_we", bus_a.imem_we, 0);
    xa(8'h82);
    chk("gg_verify_hold", bus_a.cpu_hold, 1);
    tick();
    chk("gg_done", bus_a.load_done, 1);
    chk("gg_hold", bus_a.cpu_hold, 0);
    chk("gg_err", bus_a.load_error, 0);

    // Zero-length frame from IDLE, then reload
    reset = 1'b1;
    tick();
    reset = 1'b0;
    xa(8'hA5);
    xa(8'h00); chk("z_len_we", bus_a.imem_we, 0);
    xa(8'h00); chk("z_chk_we", bus_a.imem_we, 0);
    tick();
    chk("z_done", bus_a.load_done, 1);
    chk("z_hold", bus_a.cpu_hold, 0);
    chk("z_we", bus_a.imem_we, 0);
    xa(8'hA5);
    chk("z_reload_hold", bus_a.cpu_hold, 1);
    chk("z_reload_done", bus_a.load_done, 0);
    xa(8'h01);
    xa(8'h05); chk_wr_a("z_w0", 8'h00, 8'h05);
    xa(8'hFB);
    tick();
    chk("z2_hold", bus_a.cpu_hold, 0);
    chk("z2_done", bus_a.load_done, 1);

    // Address wrap and in-frame sync byte on the FE-based instance
    xb(8'hA5);
    xb(8'h03);
    xb(8'hA5); chk_wr_b("wr_w0", 8'hFE, 8'hA5);
    xb(8'h01); chk_wr_b("wr_w1", 8'hFF, 8'h01);
    xb(8'h02); chk_wr_b("wr_w2", 8'h00, 8'h02);
    xb(8'h58);
    chk("wr_verify_we", bus_b.imem_we, 0);
    tick();
    chk("wr_done", bus_b.load_done, 1);
    chk("wr_err", bus_b.load_error, 0);
    chk("wr_hold", bus_b.cpu_hold, 0);

    // Reset in the middle of a 4-byte frame
    reset = 1'b1;
    tick();
    reset = 1'b0;
    xa(8'hA5);
    xa(8'h04);
    xa(8'h01); chk_wr_a("rm_w0", 8'h00, 8'h01);
    xa(8'h02); chk_wr_a("rm_w1", 8'h01, 8'h02);
    reset = 1'b1;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'h03;
    tick();
    reset = 1'b0;
    chk_reset_a("rm_rst");
    bus_a.in_data = 8'h04;
    tick();
    bus_a.in_valid = 1'b0;
    chk("rm_after_we", bus_a.imem_we, 0);
    chk("rm_after_hold", bus_a.cpu_hold, 1);
    xa(8'hA5);
    xa(8'h02);
    xa(8'hC0); chk_wr_a("rm_n_w0", 8'h00, 8'hC0);
    xa(8'h40); chk_wr_a("rm_n_w1", 8'h01, 8'h40);
    xa(8'h00);
    tick();
    chk("rm_n_done", bus_a.load_done, 1);
    chk("rm_n_hold", bus_a.cpu_hold, 0);
    chk("rm_n_err", bus_a.load_error, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream boot loader sitting directly upstream of the CPU core. It accepts framed program images over a valid/ready byte interface and writes them into the loadable instruction memory. It holds the core in reset, through `cpu_hold`, which is ORed into the core's `reset`, until a complete, checksum-verified image has been written.

## Interface
- `SYNC_BYTE`, 8'hA5, frame start marker.
- `LOAD_BASE`, 8'h00, first instruction-memory address written by each frame.
- `clk` input 1: system clock. One clock domain; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_data` input 8: incoming byte.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts `in_data` this cycle. A byte transfers when `in_valid && in_ready`.
- `imem_we` output 1: instruction-memory write strobe, one cycle per data byte.
- `imem_addr` output 8: write address.
- `imem_wdata` output 8: write data.
- `cpu_hold` output 1: keep the CPU in reset. High until a good frame completes.
- `load_done` output 1: last frame verified good. Level signal.
- `load_error` output 1: checksum failure. Sticky until `reset`.

## Operation
- State machine: IDLE, LEN, DATA, CHECK, VERIFY, DONE, ERROR.
- IDLE:
  - Accepts every byte.
  - A byte equal to `SYNC_BYTE` goes to LEN. Any other byte is consumed and discarded.
- LEN:
  - The accepted byte is loaded into `remaining` (8-bit).
  - Clears `sum` to 0 and sets `wr_ptr` to `LOAD_BASE`.
  - Next state is DATA if the length is nonzero, otherwise CHECK.
- DATA, on each accepted byte:
  - Registers `imem_we`=1, `imem_addr`=`wr_ptr`, `imem_wdata`=byte.
  - `wr_ptr` += 1, wrapping 8'hFF to 8'h00.
  - `sum` += byte, mod 256.
  - `remaining` -= 1.
  - After the byte that takes `remaining` to 0, goes to CHECK.
- CHECK: the accepted byte is added to `sum` (mod 256), then goes to VERIFY.
- VERIFY:
  - Lasts one cycle; `in_ready`=0.
  - If `sum`==0, goes to DONE and sets `load_done`=1, `cpu_hold`=0.
  - Otherwise goes to ERROR and sets `load_error`=1.
- DONE:
  - Accepts bytes.
  - `SYNC_BYTE` starts a reload: goes to LEN, `cpu_hold`=1, `load_done`=0, on the accepting edge.
  - Other bytes are discarded.
- ERROR: `in_ready`=0 and `cpu_hold`=1 permanently; exited only by `reset`.
- Inside a frame (LEN/DATA/CHECK), a `SYNC_BYTE` value is ordinary data with no resync.
- Length 8'hFF writes 255 bytes. A frame may wrap the address past 8'hFF; later bytes overwrite earlier ones, and no error is raised.

## Timing
- Reset values:
  - State IDLE; `in_ready`=1, `cpu_hold`=1.
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `load_done`=0, `load_error`=0.
  - Internal `sum`, `remaining` and `wr_ptr` cleared.
- `in_ready` is a combinational decode of state only: 1 in IDLE, LEN, DATA, CHECK, DONE; 0 in VERIFY and ERROR. It never depends on `in_valid`.
- Write latency:
  - `imem_we`/`imem_addr`/`imem_wdata` are registered and appear the cycle after the byte is accepted.
  - `imem_we` is high for exactly one cycle per data byte.
  - Back-to-back accepted bytes give back-to-back write strobes.
- `in_valid` low in any state: no state change, no write.
- Release latency: `cpu_hold` falls and `load_done` rises on the edge ending VERIFY, i.e. 2 cycles after the checksum byte is accepted. The last `imem_we` has already completed by then.
- `reset` mid-frame:
  - Aborts the frame and returns all outputs to reset values on the next edge.
  - Memory bytes already written are left as-is.
- `reset` has priority over every transfer in the same cycle.

## Test plan
- Good frame, streamed continuously: A5, 03, 11, 22, 33, checksum 9A.
  - Expect writes 0←11, 1←22, 2←33 on consecutive cycles.
  - `cpu_hold` falls 2 cycles after 9A is accepted; `load_done`=1, `load_error`=0.
- Bad checksum: A5, 02, 10, 20, 00.
  - Expect 2 writes, then `load_error`=1, `in_ready`=0, `cpu_hold` stays 1.
  - Further bytes are ignored until `reset`, after which the loader is back in IDLE.
- Garbage then frame with gaps: 00, FF, 5A, then A5, 01, 7E, 82, with `in_valid` toggled 1/0 each cycle.
  - Garbage is discarded with no writes.
  - One write 0←7E; DONE reached.
- Zero length plus reload: A5, 00, 00 gives DONE with no writes.
  - Then A5, 01, 05, FB: `cpu_hold` rises on the sync byte, write 0←05, `cpu_hold` falls again.
- Wrap and in-frame sync, with `LOAD_BASE`=8'hFE: A5, 03, A5, 01, 02, checksum 58.
  - Writes FE←A5, FF←01, 00←02; no resync occurs.
  - Good checksum.
- Reset mid-DATA: assert `reset` after the 2nd data byte of a 4-byte frame.
  - Outputs return to reset values the next cycle; no further writes.
  - The next full frame loads correctly.
